rpm_pid_controller: RTL and testbench
=====================================

Name: rpm_pid_controller

Overview:
- Downstream consumer of the tachometer interface's measured RPM.
- On each 10 kHz sample strobe it computes a PID correction from target RPM minus actual RPM. It then emits a saturated unsigned PWM duty word for the motor PWM generator.
- Multi-cycle sequential datapath with a single shared multiplier, driven by an FSM.

Parameters:
- RPM_W, 21, width of RPM inputs (matches tachometer output).
- DUTY_W, 10, duty output width; full scale 2^DUTY_W-1.
- KP, 4, proportional gain (unsigned 8-bit).
- KI, 1, integral gain (unsigned 8-bit).
- KD, 2, derivative gain (unsigned 8-bit).
- SHIFT, 4, arithmetic right shift applied to the PID sum (fixed-point scaling).
- INT_LIMIT, 262143, symmetric anti-windup clamp on the integral accumulator.

Ports:
- clk_in, in, 1, system clock, 125 MHz.
- reset_in, in, 1, synchronous active-low reset.
- enable_in, in, 1, controller enable; low forces idle/cleared state.
- sample_en_in, in, 1, one-cycle 10 kHz sample strobe.
- target_rpm_in, in, RPM_W, commanded speed (unsigned).
- actual_rpm_in, in, RPM_W, measured speed (unsigned), from the tachometer stage.
- duty_out, out, DUTY_W, PWM duty command.
- duty_valid_out, out, 1, one-cycle pulse when duty_out updates.
- busy_out, out, 1, high while the FSM is not IDLE.

Behaviour:
- Reset (reset_in=0 at a clk_in edge) values:
  - duty_out=0, duty_valid_out=0, busy_out=0.
  - integral=0, e_prev=0, state=IDLE.
  - Reset mid-computation aborts the computation with no valid pulse.
- enable_in=0: same clears as reset, except duty_out is forced to 0 on the next edge. Strobes are ignored.
- FSM states: IDLE, ERR, PTERM, ITERM, DTERM, SUM, OUT.
  - IDLE -> ERR on sample_en_in=1 with enable_in=1. Inputs are latched on that edge.
  - ERR: e = signed(target) - signed(actual), 22-bit signed.
  - PTERM: acc = KP*e.
  - ITERM: integral = clamp(integral+e, -INT_LIMIT, +INT_LIMIT); acc += KI*integral.
  - DTERM: acc += KD*(e - e_prev); e_prev <= e.
  - SUM: acc >>>= SHIFT (arithmetic).
  - OUT: duty_out = clamp(acc, 0, 2^DUTY_W-1); duty_valid_out=1 for one cycle; return to IDLE.
- Latency: duty_valid_out asserts exactly 6 cycles after the strobe edge (5 without derivative).
- Arithmetic: accumulator is 40-bit signed. A single multiplier is shared, with 8-bit unsigned gain x 32-bit signed operand.
- Strobe while busy_out=1: ignored, with no queuing. integral and e_prev are untouched by the dropped sample.
- Negative sum: duty 0. Overflow beyond full scale: duty saturates at 2^DUTY_W-1.
- Integral clamp is applied before multiplication, so the stored integral never exceeds ±INT_LIMIT.

Optional Feature:
- PID_DERIVATIVE_EN defined: DTERM state present; latency 6; e_prev register exists.
- Not defined:
  - DTERM is removed and ITERM goes directly to SUM; latency 5.
  - e_prev is not implemented; the Kd contribution is zero.
  - KD parameter is ignored.

Decomposition:
- Shared package pid_pkg holds:
  - state enum pid_state_t.
  - ACC_W=40 and INT_W=32 constants.
  - signed typedefs err_t (22-bit) and acc_t (40-bit).
- One natural sub-module, sat_clamp: a parameterised signed-to-range saturator, used for both the integral clamp and the duty clamp.

Test Plan:
- Reset then enable, target=300, actual=0, one strobe -> e=300, I=300, D=300.
  - With derivative: duty_out=(1200+300+600)>>>4=131, valid 6 cycles after the strobe.
  - Without derivative: 1500>>>4=93, valid after 5 cycles.
- Target=0, actual=300 from zero state -> negative sum; duty_out=0, valid pulse still issued.
- INT_LIMIT=1000, target=300, actual=0, 5 strobes -> integral sequence 300, 600, 900, 1000, 1000 (clamped). Final duty = (1200+1000+0)>>>4=137 with derivative.
- Target=2000000, actual=0 -> duty_out saturates at 1023.
- Strobe issued 2 cycles after a prior strobe -> second strobe dropped. Exactly one valid pulse; integral incremented once.
- reset_in=0 asserted in PTERM, and separately enable_in=0 mid-compute -> no valid pulse; duty_out=0, integral=0 next cycle. The next strobe reproduces the first-sample result 131.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared types and widths for the RPM PID controller datapath.
package pid_pkg;

    localparam int ACC_W = 40;
    localparam int INT_W = 32;
    localparam int ERR_W = 22;

    typedef logic signed [ERR_W-1:0] err_t;
    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [INT_W-1:0] int_t;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        PTERM,
        ITERM,
        DTERM,
        SUM,
        OUT
    } pid_state_t;

endpackage

// File: rtl/sat_clamp.sv
// Signed saturator: clamps a signed value into [LO, HI] and
// truncates the result to OUT_W bits.
module sat_clamp #(
    parameter int IN_W = 40,
    parameter int OUT_W = 10,
    parameter logic signed [IN_W-1:0] LO = '0,
    parameter logic signed [IN_W-1:0] HI = '0
) (
    input  logic signed [IN_W-1:0]  value,
    output logic        [OUT_W-1:0] clamped
);

    logic signed [IN_W-1:0] c;

    always_comb begin
        c = value;
        if (value < LO) begin
            c = LO;
        end else if (value > HI) begin
            c = HI;
        end
        clamped = OUT_W'(c);
    end

endmodule

// File: rtl/rpm_pid_controller.sv
// Sequential PID speed controller, one shared multiplier, FSM driven.
// Define PID_DERIVATIVE_EN to include the derivative (DTERM) stage.
module rpm_pid_controller
    import pid_pkg::*;
#(
    parameter int         RPM_W     = 21,
    parameter int         DUTY_W    = 10,
    parameter logic [7:0] KP        = 8'd4,
    parameter logic [7:0] KI        = 8'd1,
    parameter logic [7:0] KD        = 8'd2,
    parameter int         SHIFT     = 4,
    parameter int         INT_LIMIT = 262143
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              enable_in,
    input  logic              sample_en_in,
    input  logic [RPM_W-1:0]  target_rpm_in,
    input  logic [RPM_W-1:0]  actual_rpm_in,
    output logic [DUTY_W-1:0] duty_out,
    output logic              duty_valid_out,
    output logic              busy_out
);

    localparam int_t INT_HI   = int_t'(INT_LIMIT);
    localparam int_t INT_LO   = -INT_HI;
    localparam acc_t DUTY_MAX = acc_t'(2 ** DUTY_W - 1);

    pid_state_t state, state_d;

    logic [RPM_W-1:0] tgt_q;
    logic [RPM_W-1:0] act_q;
    err_t             e_q;
    int_t             integral;
    acc_t             acc;
`ifdef PID_DERIVATIVE_EN
    err_t             e_prev;
`endif

    int_t             int_sum;
    logic [INT_W-1:0] int_clamped;
    logic [DUTY_W-1:0] duty_sat;
    int_t             d_op;
    logic [7:0]       gain;
    int_t             mul_op;
    acc_t             product;

    assign int_sum = int_t'(e_q) + integral;

`ifdef PID_DERIVATIVE_EN
    assign d_op = int_t'(e_q) - int_t'(e_prev);
`else
    assign d_op = '0;
`endif

    sat_clamp #(
        .IN_W (INT_W),
        .OUT_W(INT_W),
        .LO   (INT_LO),
        .HI   (INT_HI)
    ) u_int_clamp (
        .value  (int_sum),
        .clamped(int_clamped)
    );

    sat_clamp #(
        .IN_W (ACC_W),
        .OUT_W(DUTY_W),
        .LO   ('0),
        .HI   (DUTY_MAX)
    ) u_duty_clamp (
        .value  (acc),
        .clamped(duty_sat)
    );

    // Operand select for the single gain multiplier
    always_comb begin
        gain   = '0;
        mul_op = '0;
        unique case (state)
            PTERM: begin
                gain   = KP;
                mul_op = int_t'(e_q);
            end
            ITERM: begin
                gain   = KI;
                mul_op = int_clamped;
            end
            DTERM: begin
                gain   = KD;
                mul_op = d_op;
            end
            default: ;
        endcase
    end

    assign product = acc_t'($signed({1'b0, gain})) * acc_t'(mul_op);

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:  if (sample_en_in) state_d = ERR;
            ERR:   state_d = PTERM;
            PTERM: state_d = ITERM;
`ifdef PID_DERIVATIVE_EN
            ITERM: state_d = DTERM;
            DTERM: state_d = SUM;
`else
            ITERM: state_d = SUM;
`endif
            SUM:   state_d = OUT;
            OUT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset_in || !enable_in) begin
            state          <= IDLE;
            tgt_q          <= '0;
            act_q          <= '0;
            e_q            <= '0;
            integral       <= '0;
            acc            <= '0;
            duty_out       <= '0;
            duty_valid_out <= 1'b0;
`ifdef PID_DERIVATIVE_EN
            e_prev         <= '0;
`endif
        end else begin
            state          <= state_d;
            duty_valid_out <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sample_en_in) begin
                        tgt_q <= target_rpm_in;
                        act_q <= actual_rpm_in;
                    end
                end
                ERR: e_q <= err_t'({1'b0, tgt_q}) - err_t'({1'b0, act_q});
                PTERM: acc <= product;
                ITERM: begin
                    integral <= int_clamped;
                    acc      <= acc + product;
                end
`ifdef PID_DERIVATIVE_EN
                DTERM: begin
                    acc    <= acc + product;
                    e_prev <= e_q;
                end
`endif
                SUM: acc <= acc >>> SHIFT;
                OUT: begin
                    duty_out       <= duty_sat;
                    duty_valid_out <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy_out = (state != IDLE);

endmodule

// File: tb/tb_rpm_pid_controller.sv
// Scoreboard bench for rpm_pid_controller (INT_LIMIT overridden to 1000).
module tb_rpm_pid_controller;

`ifdef PID_DERIVATIVE_EN
    localparam int LAT   = 6;
    localparam int FIRST = 131;
    localparam int WIND [5] = '{131, 112, 131, 137, 137};
`else
    localparam int LAT   = 5;
    localparam int FIRST = 93;
    localparam int WIND [5] = '{93, 112, 131, 137, 137};
`endif

    typedef struct {
        int duty;
        int edge_n;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        enable_in;
    logic        sample_en_in;
    logic [20:0] target_rpm_in;
    logic [20:0] actual_rpm_in;
    logic [9:0]  duty_out;
    logic        duty_valid_out;
    logic        busy_out;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    rpm_pid_controller #(
        .INT_LIMIT(1000)
    ) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .enable_in     (enable_in),
        .sample_en_in  (sample_en_in),
        .target_rpm_in (target_rpm_in),
        .actual_rpm_in (actual_rpm_in),
        .duty_out      (duty_out),
        .duty_valid_out(duty_valid_out),
        .busy_out      (busy_out)
    );

    always #4 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: pop expectation on every valid pulse
    always @(negedge clk_in) begin
        exp_t e;
        if (duty_valid_out) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: pulse with duty %0d, required none",
                         duty_out);
            end else begin
                e = sb.pop_front();
                check("duty", int'(duty_out), e.duty);
                check("latency", cyc - e.edge_n, LAT);
            end
        end
    end

    task automatic strobe(input int t, input int a, input bit push,
                          input int exp_duty);
        exp_t e;
        @(negedge clk_in);
        target_rpm_in = 21'(t);
        actual_rpm_in = 21'(a);
        sample_en_in  = 1'b1;
        e.duty   = exp_duty;
        e.edge_n = cyc + 1;
        if (push) sb.push_back(e);
        @(negedge clk_in);
        sample_en_in = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy_out) && n < 40) begin
            @(negedge clk_in);
            n++;
        end
        check("pending_after_wait", sb.size(), 0);
        @(negedge clk_in);
    endtask

    task automatic clear();
        @(negedge clk_in);
        enable_in = 1'b0;
        @(negedge clk_in);
        enable_in = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_in      = 1'b0;
        enable_in     = 1'b1;
        sample_en_in  = 1'b0;
        target_rpm_in = '0;
        actual_rpm_in = '0;
        repeat (3) @(negedge clk_in);
        check("reset_duty", int'(duty_out), 0);
        check("reset_valid", int'(duty_valid_out), 0);
        check("reset_busy", int'(busy_out), 0);
        reset_in = 1'b1;

        strobe(300, 0, 1'b1, FIRST);
        drain();

        clear();
        strobe(0, 300, 1'b1, 0);
        drain();

        clear();
        for (int i = 0; i < 5; i++) begin
            strobe(300, 0, 1'b1, WIND[i]);
            drain();
        end

        clear();
        strobe(2000000, 0, 1'b1, 1023);
        drain();

        // Second strobe lands while busy and must be dropped
        clear();
        strobe(300, 0, 1'b1, FIRST);
        strobe(0, 300, 1'b0, 0);
        drain();
        strobe(300, 0, 1'b1, 112);
        drain();

        // Reset while in PTERM
        strobe(300, 0, 1'b0, 0);
        @(negedge clk_in);
        reset_in = 1'b0;
        @(negedge clk_in);
        check("abort_reset_duty", int'(duty_out), 0);
        check("abort_reset_busy", int'(busy_out), 0);
        reset_in = 1'b1;
        repeat (8) @(negedge clk_in);
        strobe(300, 0, 1'b1, FIRST);
        drain();

        // Enable dropped while in ITERM
        strobe(300, 0, 1'b0, 0);
        @(negedge clk_in);
        @(negedge clk_in);
        enable_in = 1'b0;
        @(negedge clk_in);
        check("abort_enable_duty", int'(duty_out), 0);
        check("abort_enable_busy", int'(busy_out), 0);
        enable_in = 1'b1;
        repeat (8) @(negedge clk_in);
        strobe(300, 0, 1'b1, FIRST);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
